very_simple_cpu: RTL and testbench



---
 rtl/vscpu_pkg.sv | 29 ++
 rtl/vscpu_alu.sv | 32 +++
 rtl/very_simple_cpu.sv | 126 ++++++++++++
 tb/tb_very_simple_cpu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared definitions for very_simple_cpu: opcodes, FSM states and instruction-word fields.
// The optional multiplier is controlled by the VSCPU_MUL_EN macro in vscpu_alu.sv and very_simple_cpu.sv.
package vscpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // Instruction word layout: [31:29] opcode, [28] immediate, [27:14] A, [13:0] B.
  localparam int IW_OP_LSB  = 29;
  localparam int IW_IMM_BIT = 28;
  localparam int IW_A_LSB   = 14;
  localparam int IW_B_LSB   = 0;
  localparam int IW_FLD_W   = 14;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DEC   = 3'd1,
    S_RDA   = 3'd2,
    S_RDB   = 3'd3,
    S_IND   = 3'd4
  } state_e;

endpackage

// File: rtl/vscpu_alu.sv
// Combinational datapath for the write-back opcodes of very_simple_cpu.
// The multiplier exists only when VSCPU_MUL_EN is defined.
module vscpu_alu
  import vscpu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] r1_i,
  input  logic [31:0] v_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = r1_i + v_i;
      OP_NAND: result_o = ~(r1_i & v_i);
      OP_SRL: begin
        // For 32..63 the left-shift amount V-32 equals V[4:0].
        if (v_i < 32'd32)      result_o = r1_i >> v_i[4:0];
        else if (v_i < 32'd64) result_o = r1_i << v_i[4:0];
        else                   result_o = '0;
      end
      OP_LT:   result_o = {31'b0, (r1_i < v_i)};
      OP_CP:   result_o = v_i;
`ifdef VSCPU_MUL_EN
      OP_MUL:  result_o = r1_i * v_i;
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/very_simple_cpu.sv
// Multi-cycle memory-to-memory CPU: FSM, PC, IW and R1; operands all live in the external RAM.
// Define VSCPU_MUL_EN to implement MUL/MULi; otherwise they execute as NOPs.
module very_simple_cpu
  import vscpu_pkg::*;
#(
  parameter int SIZE = 14
) (
  input  logic            clk,
  input  logic            rst,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM,
  input  logic [31:0]     data_fromRAM,
  output logic [2:0]      dbg_state_o
);

  localparam logic [SIZE-1:0] PC_ONE = 1;

  state_e          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [31:0]     iw_q, iw_d;
  logic [31:0]     r1_q, r1_d;

  logic [2:0]      op;
  logic            imm;
  logic [SIZE-1:0] a_fld, b_fld;
  logic [31:0]     v;
  logic [31:0]     alu_result;

  assign op    = iw_q[IW_OP_LSB +: 3];
  assign imm   = iw_q[IW_IMM_BIT];
  assign a_fld = iw_q[IW_A_LSB +: SIZE];
  assign b_fld = iw_q[IW_B_LSB +: SIZE];
  // In RDB the RAM is returning *B, so the non-immediate operand is taken straight from it.
  assign v     = imm ? {{(32-SIZE){1'b0}}, b_fld} : data_fromRAM;

  assign dbg_state_o = state_q;

  vscpu_alu u_alu (
    .op_i     (op),
    .r1_i     (r1_q),
    .v_i      (v),
    .result_o (alu_result)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iw_d       = iw_q;
    r1_d       = r1_q;
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
    case (state_q)
      S_FETCH: begin
        addr_toRAM = pc_q;
        state_d    = S_DEC;
      end
      S_DEC: begin
        // IW is not registered yet, so A comes from the word arriving now.
        iw_d       = data_fromRAM;
        addr_toRAM = data_fromRAM[IW_A_LSB +: SIZE];
        state_d    = S_RDA;
      end
      S_RDA: begin
        r1_d       = data_fromRAM;
        addr_toRAM = b_fld;
        state_d    = S_RDB;
      end
      S_RDB: begin
        pc_d    = pc_q + PC_ONE;
        state_d = S_FETCH;
        case (op)
          OP_CPI: begin
            if (!imm) begin
              addr_toRAM = data_fromRAM[SIZE-1:0];
              state_d    = S_IND;
            end else begin
              wrEn       = 1'b1;
              addr_toRAM = r1_q[SIZE-1:0];
              data_toRAM = data_fromRAM;
            end
          end
          OP_BZJ: begin
            if (imm)                      pc_d = r1_q[SIZE-1:0] + b_fld;
            else if (data_fromRAM == '0)  pc_d = r1_q[SIZE-1:0];
          end
          OP_MUL: begin
`ifdef VSCPU_MUL_EN
            wrEn       = 1'b1;
            addr_toRAM = a_fld;
            data_toRAM = alu_result;
`endif
          end
          default: begin
            wrEn       = 1'b1;
            addr_toRAM = a_fld;
            data_toRAM = alu_result;
          end
        endcase
      end
      S_IND: begin
        wrEn       = 1'b1;
        addr_toRAM = a_fld;
        data_toRAM = data_fromRAM;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      iw_q    <= '0;
      r1_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      r1_q    <= r1_d;
    end
  end

endmodule

// File: tb/tb_very_simple_cpu.sv
// Bench for very_simple_cpu: directed programs plus random memory images, checked against an
// instruction-level model of the ISA with its own memory image.
module tb_very_simple_cpu;
  import vscpu_pkg::*;

  localparam int SIZE  = 14;
  localparam int DEPTH = 1 << SIZE;

  // clock / reset
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic [2:0]      dbg_state;
  logic            fill_en = 1'b0;

  always #5 clk = ~clk;

  very_simple_cpu #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM),
    .dbg_state_o  (dbg_state)
  );

  logic [31:0]     ram   [DEPTH];
  logic [31:0]     m_mem [DEPTH];
  logic [SIZE-1:0] m_pc;

  // Block RAM with one-cycle read latency; fill_en copies the model image in one edge.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= m_mem[k];
    end else begin
      if (wrEn) ram[addr_toRAM] <= data_toRAM;
      data_fromRAM <= ram[addr_toRAM];
    end
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [SIZE+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
  endtask

  task automatic model_write(input logic [SIZE-1:0] wa, input logic [31:0] wd);
    exp_q.push_back({wa, wd});
    m_mem[wa] = wd;
  endtask

  // Enters and holds reset for 10 cycles, loading the RAM from the model image.
  task automatic do_reset();
    rst = 1'b1;
    fill_en = 1'b1;
    @(posedge clk);
    #1 fill_en = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("rst_wren", 64'(wrEn), 64'd0);
      check("rst_addr", 64'(addr_toRAM), 64'd0);
      @(negedge clk);
    end
    check("rst_state", 64'(dbg_state), 64'(S_FETCH));
    rst = 1'b0;
    m_pc = '0;
    exp_q.delete();
  endtask

  // Executes one instruction in the model, then observes the DUT for the expected cycle count.
  task automatic run_instr();
    logic [31:0]     iw, ra, rb, v, r;
    logic [2:0]      op;
    logic            imm;
    logic [SIZE-1:0] a, b, npc;
    logic [SIZE+31:0] got_w, exp_w;
    int ncyc, nwr, exp_cnt;
    iw  = m_mem[m_pc];
    op  = iw[31:29];
    imm = iw[28];
    a   = iw[27:14];
    b   = iw[13:0];
    ra  = m_mem[a];
    rb  = m_mem[b];
    v   = imm ? {18'd0, b} : rb;
    ncyc = 4;
    npc  = m_pc + 14'd1;
    case (op)
      3'd0: model_write(a, ra + v);
      3'd1: model_write(a, ~(ra & v));
      3'd2: begin
        if (v < 32)      r = ra >> v;
        else if (v < 64) r = ra << (v - 32);
        else             r = 32'd0;
        model_write(a, r);
      end
      3'd3: model_write(a, (ra < v) ? 32'd1 : 32'd0);
      3'd4: model_write(a, v);
      3'd5: begin
        if (imm) model_write(ra[SIZE-1:0], rb);
        else begin
          ncyc = 5;
          model_write(a, m_mem[rb[SIZE-1:0]]);
        end
      end
      3'd6: begin
        if (imm)            npc = ra[SIZE-1:0] + b;
        else if (rb == 0)   npc = ra[SIZE-1:0];
      end
      default: begin
`ifdef VSCPU_MUL_EN
        model_write(a, ra * v);
`endif
      end
    endcase
    exp_cnt = exp_q.size();
    nwr = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) check("fetch_addr", 64'(addr_toRAM), 64'(m_pc));
      if (wrEn) begin
        nwr++;
        check("write_cycle", 64'(c), 64'(ncyc - 1));
        if (exp_q.size() > 0) begin
          got_w = {addr_toRAM, data_toRAM};
          exp_w = exp_q.pop_front();
          check("write", 64'(got_w), 64'(exp_w));
        end
      end
      @(negedge clk);
    end
    check("write_count", 64'(nwr), 64'(exp_cnt));
    exp_q.delete();
    m_pc = npc;
  endtask

  initial begin
    // Directed program: NAND, ADDi, CPIi, CPI, SRL boundaries, MUL, branches.
    clear_model();
    m_mem[0]  = 32'h20114045;  m_mem[69] = 32'd1;
    m_mem[1]  = 32'h10114001;
    m_mem[2]  = 32'hB0118064;  m_mem[70] = 32'd1000;  m_mem[100] = 32'd6;
    m_mem[3]  = 32'hA011C048;  m_mem[72] = 32'd2;
    m_mem[4]  = 32'h50140001;  m_mem[80] = 32'h80000001;
    m_mem[5]  = 32'h50144021;  m_mem[81] = 32'h80000001;
    m_mem[6]  = 32'h50148040;  m_mem[82] = 32'h80000001;
    m_mem[7]  = 32'hE014C054;  m_mem[83] = 32'h00010000;  m_mem[84] = 32'h00010001;
    m_mem[8]  = 32'hC015C058;  m_mem[87] = 32'd500;       m_mem[88] = 32'd5;
    m_mem[9]  = 32'hC0154056;  m_mem[85] = 32'd19;        m_mem[86] = 32'd0;
    m_mem[19] = 32'hD0050013;  m_mem[20] = 32'd0;
    do_reset();
    check("first_fetch", 64'(addr_toRAM), 64'd0);
    run_instr();  check("nand", 64'(ram[69]), 64'hFFFFFFFE);
    run_instr();  check("addi", 64'(ram[69]), 64'hFFFFFFFF);
    run_instr();  check("cpii", 64'(ram[1000]), 64'd6);
    run_instr();  check("cpi", 64'(ram[71]), 64'hB0118064);
    run_instr();  check("srl_1", 64'(ram[80]), 64'h40000000);
    run_instr();  check("srl_33", 64'(ram[81]), 64'h00000002);
    run_instr();  check("srl_64", 64'(ram[82]), 64'h0);
    run_instr();  check("mul", 64'(ram[83]), 64'h00010000);
    run_instr();  check("bzj_not_taken", 64'(addr_toRAM), 64'd9);
    run_instr();  check("bzj_taken", 64'(addr_toRAM), 64'd19);
    for (int k = 0; k < 3; k++) run_instr();
    check("bzji_loop", 64'(addr_toRAM), 64'd19);

    // Random memory images: instruction words and small operands mixed.
    for (int img = 0; img < 3; img++) begin
      for (int k = 0; k < DEPTH; k++)
        m_mem[k] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 70);
      do_reset();
      repeat (300) run_instr();
    end

    // Reset mid-instruction: the pending write in RDB must be abandoned.
    clear_model();
    m_mem[0]  = 32'h10114001;
    m_mem[69] = 32'd5;
    do_reset();
    repeat (3) @(negedge clk);
    check("pre_rst_wren", 64'(wrEn), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wren", 64'(wrEn), 64'd0);
    check("mid_rst_addr", 64'(addr_toRAM), 64'd0);
    check("mid_rst_data", 64'(data_toRAM), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("abandoned_write", 64'(ram[69]), 64'd5);
    rst = 1'b0;
    m_pc = '0;
    exp_q.delete();
    run_instr();
    check("after_rst_addi", 64'(ram[69]), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
